// File: rtl/phase_pkg.sv
// phase_pkg: shared sequencer state encoding and phase constants
package phase_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} seq_state_t;
    localparam int NUM_PHASES = 5;
    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);
endpackage

// File: rtl/exec_debounce.sv
// exec_debounce: synchronizes, debounces and rising-edge-detects the raw exec button
module exec_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_exec,
    output logic o_exec_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_pulse;
    logic          w_diff;
    logic          w_done;
    assign w_diff = r_sync[1] != r_level;
    // the level flips on the last of DEBOUNCE_CYCLES consecutive differing samples
    assign w_done = w_diff && r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_exec};
            r_cnt     <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
            r_level   <= w_done ? r_sync[1] : r_level;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
        end
    end
    assign o_exec_pulse = r_pulse;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: steps the 5-phase instruction cycle in run/step modes, stopping at
// instruction boundaries on user stop or datapath halt
module phase_sequencer import phase_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic               step_mode,
    input  logic               halt,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);
    seq_state_t         r_state;
    seq_state_t         w_state;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count;
    logic               r_valid;
    logic               r_halted;
    logic               r_stop;
    logic               w_stop;
    logic               w_valid;
    logic               w_halted;
    logic               w_pulse;
    logic               w_last;

    exec_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock        (clock),
        .reset        (reset),
        .i_exec       (exec),
        .o_exec_pulse (w_pulse)
    );

    assign w_last = r_phase == PHASE_LAST;

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_stop  = r_stop;
        w_count = r_count;
        case (r_state)
            IDLE: begin
                w_phase = '0;
                if (w_pulse) w_state = step_mode ? STEP : RUN;
            end
            RUN: begin
                // a press landing in phase 4 only arms the stop for the next instruction
                w_stop  = r_stop | w_pulse;
                w_phase = w_last ? '0 : r_phase + 1'b1;
                w_count = w_last ? r_count + 1'b1 : r_count;
                if (w_last) w_state = halt ? HALTED : r_stop ? IDLE : RUN;
            end
            STEP: begin
                w_phase = w_last ? '0 : r_phase + 1'b1;
                w_count = w_last ? r_count + 1'b1 : r_count;
                if (w_last) w_state = halt ? HALTED : IDLE;
            end
            HALTED: begin
                w_phase = '0;
                if (w_pulse) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
        if (w_state != RUN) w_stop = 1'b0;
        w_valid  = w_state == RUN || w_state == STEP;
        w_halted = w_state == HALTED;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_stop   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state;
            r_phase  <= w_phase;
            r_valid  <= w_valid;
            r_halted <= w_halted;
            r_stop   <= w_stop;
            r_count  <= w_count;
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_valid;
    assign halted      = r_halted;
    assign instr_count = r_count;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scenarios for the phase sequencer with DEBOUNCE_CYCLES=4
module tb_phase_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        exec;
    logic        step_mode;
    logic        halt;
    logic [2:0]  phase;
    logic        phase_valid;
    logic        halted;
    logic [15:0] instr_count;
    int          n_vec = 0;
    int          n_err = 0;

    phase_sequencer #(.DEBOUNCE_CYCLES(4), .COUNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .step_mode   (step_mode),
        .halt        (halt),
        .phase       (phase),
        .phase_valid (phase_valid),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        exec = 1'b0;
        halt = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // press ends on the cycle where exec_pulse is visible, with exec released
    task automatic press;
        exec = 1'b1;
        repeat (7) tick;
        exec = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_vec++;
        if ({phase_valid, phase} !== 4'b0000) begin n_err++; $display("FAIL reset_phase got %b exp 0000", {phase_valid, phase}); end
        n_vec++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_vec++;
        if (instr_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", instr_count); end
        tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b0000) begin n_err++; $display("FAIL reset_idle_hold got %b exp 0000", {phase_valid, phase}); end
    endtask

    task automatic test_start_run;
        logic [3:0] exp;
        do_reset;
        step_mode = 1'b0;
        exec = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 10) exec = 1'b0;
            n_vec++;
            if (dut.u_debounce.o_exec_pulse !== 1'(i == 7)) begin n_err++; $display("FAIL run_pulse t=%0d got %b exp %b", i, dut.u_debounce.o_exec_pulse, i == 7); end
            if (i >= 8) begin
                exp = {1'b1, 3'((i - 8) % 5)};
                n_vec++;
                if ({phase_valid, phase} !== exp) begin n_err++; $display("FAIL run_phase t=%0d got %b exp %b", i, {phase_valid, phase}, exp); end
            end
        end
    endtask

    task automatic test_bounce;
        int np;
        np = 0;
        do_reset;
        step_mode = 1'b0;
        exec = 1'b1; tick;
        exec = 1'b0; tick;
        exec = 1'b1; tick;
        exec = 1'b0; tick;
        exec = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick;
            if (dut.u_debounce.o_exec_pulse === 1'b1) np++;
            if (i == 7) begin
                n_vec++;
                if (dut.u_debounce.o_exec_pulse !== 1'b1) begin n_err++; $display("FAIL bounce_pulse_time got %b exp 1", dut.u_debounce.o_exec_pulse); end
            end
        end
        exec = 1'b0;
        n_vec++;
        if (np != 1) begin n_err++; $display("FAIL bounce_pulse_count got %0d exp 1", np); end
    endtask

    task automatic test_step;
        logic [3:0] exp;
        do_reset;
        step_mode = 1'b1;
        exec = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            if (i == 7) exec = 1'b0;
            if (i == 9) step_mode = 1'b0;
            exp = (i >= 8 && i <= 12) ? {1'b1, 3'(i - 8)} : 4'b0000;
            n_vec++;
            if ({phase_valid, phase} !== exp) begin n_err++; $display("FAIL step_phase t=%0d got %b exp %b", i, {phase_valid, phase}, exp); end
        end
        n_vec++;
        if (instr_count !== 16'd1) begin n_err++; $display("FAIL step_count got %0d exp 1", instr_count); end
    endtask

    task automatic test_stop;
        do_reset;
        step_mode = 1'b0;
        press;
        repeat (11) tick;
        exec = 1'b1;
        repeat (7) tick;
        exec = 1'b0;
        n_vec++;
        if ({dut.u_debounce.o_exec_pulse, phase_valid, phase} !== 5'b11010) begin n_err++; $display("FAIL stop_p2_press got %b exp 11010", {dut.u_debounce.o_exec_pulse, phase_valid, phase}); end
        tick; tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b1100) begin n_err++; $display("FAIL stop_p2_last got %b exp 1100", {phase_valid, phase}); end
        tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b0000) begin n_err++; $display("FAIL stop_p2_idle got %b exp 0000", {phase_valid, phase}); end
        n_vec++;
        if (instr_count !== 16'd4) begin n_err++; $display("FAIL stop_p2_count got %0d exp 4", instr_count); end
        do_reset;
        press;
        repeat (8) tick;
        exec = 1'b1;
        repeat (7) tick;
        exec = 1'b0;
        n_vec++;
        if ({dut.u_debounce.o_exec_pulse, phase_valid, phase} !== 5'b11100) begin n_err++; $display("FAIL stop_p4_press got %b exp 11100", {dut.u_debounce.o_exec_pulse, phase_valid, phase}); end
        tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b1000) begin n_err++; $display("FAIL stop_p4_wrap got %b exp 1000", {phase_valid, phase}); end
        repeat (4) tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b1100) begin n_err++; $display("FAIL stop_p4_last got %b exp 1100", {phase_valid, phase}); end
        tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b0000) begin n_err++; $display("FAIL stop_p4_idle got %b exp 0000", {phase_valid, phase}); end
        n_vec++;
        if (instr_count !== 16'd4) begin n_err++; $display("FAIL stop_p4_count got %0d exp 4", instr_count); end
    endtask

    task automatic test_halt;
        do_reset;
        step_mode = 1'b0;
        press;
        tick; tick;
        halt = 1'b1;
        repeat (3) tick;
        halt = 1'b0;
        n_vec++;
        if ({halted, phase_valid, phase} !== 5'b01100) begin n_err++; $display("FAIL halt_early_p4 got %b exp 01100", {halted, phase_valid, phase}); end
        tick;
        n_vec++;
        if ({halted, phase_valid, phase} !== 5'b01000) begin n_err++; $display("FAIL halt_early_wrap got %b exp 01000", {halted, phase_valid, phase}); end
        repeat (5) tick;
        exec = 1'b1;
        repeat (7) tick;
        exec = 1'b0;
        tick; tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b1100 || instr_count !== 16'd3) begin n_err++; $display("FAIL halt_pre got %b cnt %0d exp 1100 cnt 3", {phase_valid, phase}, instr_count); end
        halt = 1'b1;
        tick;
        halt = 1'b0;
        n_vec++;
        if ({halted, phase_valid, phase} !== 5'b10000) begin n_err++; $display("FAIL halt_enter got %b exp 10000", {halted, phase_valid, phase}); end
        n_vec++;
        if (instr_count !== 16'd4) begin n_err++; $display("FAIL halt_count got %0d exp 4", instr_count); end
        repeat (4) tick;
        exec = 1'b1;
        repeat (7) tick;
        exec = 1'b0;
        n_vec++;
        if (halted !== 1'b1) begin n_err++; $display("FAIL halt_hold got %b exp 1", halted); end
        tick;
        n_vec++;
        if ({halted, phase_valid, phase} !== 5'b00000) begin n_err++; $display("FAIL halt_exit got %b exp 00000", {halted, phase_valid, phase}); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        step_mode = 1'b0;
        press;
        repeat (29) tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b1011 || instr_count !== 16'd5) begin n_err++; $display("FAIL midrst_pre got %b cnt %0d exp 1011 cnt 5", {phase_valid, phase}, instr_count); end
        reset = 1'b1;
        tick;
        n_vec++;
        if ({halted, phase_valid, phase} !== 5'b00000 || instr_count !== 16'd0) begin n_err++; $display("FAIL midrst_out got %b cnt %0d exp 00000 cnt 0", {halted, phase_valid, phase}, instr_count); end
        reset = 1'b0;
        tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b0000) begin n_err++; $display("FAIL midrst_idle got %b exp 0000", {phase_valid, phase}); end
    endtask

    task automatic test_wrap;
        do_reset;
        step_mode = 1'b1;
        press;
        tick; tick;
        force dut.r_count = 16'hFFFF;
        tick;
        release dut.r_count;
        n_vec++;
        if (instr_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preset got %h exp ffff", instr_count); end
        tick; tick;
        n_vec++;
        if ({phase_valid, phase} !== 4'b1100) begin n_err++; $display("FAIL wrap_p4 got %b exp 1100", {phase_valid, phase}); end
        tick;
        n_vec++;
        if (instr_count !== 16'h0000 || phase_valid !== 1'b0) begin n_err++; $display("FAIL wrap_count got %h valid %b exp 0000 valid 0", instr_count, phase_valid); end
    endtask

    initial begin
        reset = 1'b1;
        exec = 1'b0;
        step_mode = 1'b0;
        halt = 1'b0;
        @(negedge clock);
        test_reset;
        test_start_run;
        test_bounce;
        test_step;
        test_stop;
        test_halt;
        test_reset_mid;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the 3-bit instruction phase that drives the processor's phase-gated clock stage, one phase per clock in the order 0,1,2,3,4. Handles the raw `exec` pushbutton (synchronize, debounce, edge-detect), supports free-run and single-instruction step modes, and stops cleanly at instruction boundaries on user stop or on `halt` from the datapath. Sits directly upstream of the control unit, which consumes `phase` and `phase_valid`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept an `exec` level change; must be ≥ 1.
- `COUNT_W`, default 16: width of `instr_count`.
- `clock`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `exec`  in  1  raw pushbutton level, asynchronous, may bounce.
- `step_mode`  in  1  1 = an accepted press runs exactly one instruction; 0 = the press toggles free-run.
- `halt`  in  1  datapath halt request; sampled only in phase 4.
- `phase`  out  3  current phase, 0..4; the value 5..7 is never driven.
- `phase_valid`  out  1  high while phases are advancing (RUN or STEP).
- `halted`  out  1  high in HALTED.
- `instr_count`  out  COUNT_W  completed instructions; wraps modulo 2^COUNT_W.

## Operation
- Exec path: 2-flop synchronizer feeds the debouncer. The debounced level updates after `DEBOUNCE_CYCLES` consecutive equal samples that differ from it. A rising edge of the debounced level produces a 1-cycle `exec_pulse`. Falling edges do nothing.
- States:
  - IDLE: phase held at 0, `phase_valid`=0.
    - `exec_pulse` with `step_mode`=1 → STEP.
    - `exec_pulse` with `step_mode`=0 → RUN.
  - RUN: phase advances every cycle, 4→0 wrap.
    - `exec_pulse` sets `stop_pending`.
    - At phase 4: if `halt`, go to HALTED. Else if `stop_pending`, go to IDLE. Else wrap to phase 0.
  - STEP: phase advances 0..4.
    - At phase 4: if `halt`, go to HALTED. Else go to IDLE.
    - `exec_pulse` is ignored.
  - HALTED: phase held at 0, `phase_valid`=0, `halted`=1.
    - `exec_pulse` → IDLE and clears `halted`.
- `instr_count` increments on every cycle in which phase 4 completes in RUN or STEP, including the cycle that enters HALTED.
- `stop_pending` clears on entry to IDLE or HALTED. A second press while it is set is ignored; it does not cancel the stop.
- `step_mode` is sampled only in IDLE. Changes during RUN or STEP have no effect until the next IDLE.

## Timing
- Reset (any state, mid-instruction included) takes effect on the next edge:
  - state=IDLE, `phase`=0, `phase_valid`=0, `halted`=0, `instr_count`=0, `stop_pending`=0.
  - Synchronizer and debouncer cleared to level 0.
- Exec latency: a clean rising edge of `exec` produces `exec_pulse` 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles later.
- Starting: the state transition occurs on the edge after `exec_pulse`. `phase`=0 with `phase_valid`=1 is visible that cycle, and phase 1 follows on the next cycle.
- One instruction = exactly 5 cycles with `phase_valid`=1.
- All outputs are registered. There is no combinational path from any input to any output.
- Simultaneous events:
  - `halt` and `stop_pending` in phase 4: HALTED wins.
  - `exec_pulse` in phase 4 of RUN: the stop applies at the end of the next instruction, not the current one.
  - `halt` outside phase 4: ignored.
- `instr_count` wraps from 2^COUNT_W−1 to 0 with no flag.

## Structure
- Package `phase_pkg` holds:
  - `seq_state_t` enum: IDLE, RUN, STEP, HALTED.
  - `NUM_PHASES`=5.
  - `PHASE_LAST`=3'd4.
  - `PHASE_W`=3.
- One sub-module, `exec_debounce`, containing the synchronizer, stability counter (width $clog2(DEBOUNCE_CYCLES+1)), debounced level and rising-edge pulse. The sequencer FSM and counters stay in `phase_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset, then `exec` held high 10 cycles with `step_mode`=0 → `exec_pulse` 7 cycles after the rise; next cycle `phase`=0 and `phase_valid`=1; phases then follow 0,1,2,3,4,0,…
- Bounce: `exec` toggles 1,0,1,0 on consecutive cycles, then holds high → exactly one `exec_pulse`, 7 cycles after the final rise.
- Step: `step_mode`=1, one press → exactly 5 cycles with `phase_valid`=1 (phases 0..4), then IDLE with `phase`=0 and `instr_count`=1.
- Stop: in RUN, press while `phase`=2 → the instruction completes through phase 4, then IDLE. If instead the pulse lands in phase 4, one further full instruction runs before IDLE.
- Halt: `halt`=1 during phases 1..3 → no effect. `halt`=1 in phase 4 together with a pending stop → HALTED with `halted`=1 and `instr_count` incremented; a press then returns to IDLE with `halted`=0.
- Reset mid-run at `phase`=3 with `instr_count`=5 → next cycle all outputs at reset values. Separately, force `instr_count`=16'hFFFF and complete one instruction → `instr_count`=0.
